dac_delay_tuner: RTL and testbench
==================================

# dac_delay_tuner

Sequencing controller for the variable-tap output IODELAYs on the two 6-bit DAC buses (DA1, DA2: 12 lanes). It accepts per-lane target tap requests and walks the addressed lane's IODELAY to the target one tap at a time using CE/INC pulses, with a settle gap after every step. It keeps a shadow table of each lane's current tap and issues the global IODELAY reset after system reset. It sits in the clk200 domain beside the IODELAY instances and drives their C/CE/INC/RST pins.

## Interface
- NUM_LANES, 12, number of IODELAY lanes; lane 0-5 = DA1[0..5], lane 6-11 = DA2[0..5]
- TAP_W, 6, tap counter width (taps 0..63)
- INIT_TAP, 0, tap value each IODELAY loads on RST (matches its ODELAY_VALUE)
- SETTLE_CYC, 4, idle cycles after each CE pulse (>= 1)

- clk200  in  1  IODELAY reference/control clock; all logic on its rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  tuning request present
- req_ready  out  1  controller can accept a request
- req_lane  in  4  target lane index
- req_tap  in  TAP_W  target tap value
- done  out  1  one-cycle pulse: accepted request finished
- err  out  1  one-cycle pulse: request rejected (lane >= NUM_LANES)
- busy  out  1  high in any state other than IDLE
- dly_ce  out  NUM_LANES  per-lane IODELAY CE, one-hot or zero
- dly_inc  out  1  shared IODELAY INC (1 = increment, 0 = decrement)
- dly_rst  out  1  shared IODELAY RST
- rd_lane  in  4  shadow-table readback lane
- rd_tap  out  TAP_W  registered readback of shadow tap for rd_lane

## Operation
- States: INIT, IDLE, STEP, SETTLE, DONE.
- INIT: entered whenever RST is sampled high. dly_rst=1. All shadow taps = INIT_TAP. Advances to IDLE one cycle after RST is sampled low.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready.
  - If req_lane >= NUM_LANES: err=1 next cycle. Stay in IDLE. Table unchanged.
  - If req_tap == shadow[req_lane]: go to DONE (no CE pulses).
  - Otherwise latch lane and target, then go to STEP.
- STEP: one cycle. dly_ce[lane]=1. dly_inc = (target > shadow[lane]). shadow[lane] moves ±1 at the end of the cycle. Go to SETTLE.
- SETTLE: SETTLE_CYC cycles with dly_ce=0 and dly_inc held. At the end, go to DONE if shadow[lane]==target, else back to STEP.
- DONE: done=1 for one cycle, then IDLE.
- Steps always move toward the target, so taps never pass 0 or 63. No wrap is possible, because any TAP_W-bit target is in range.
- Only one request is in flight at a time. req_valid outside IDLE is ignored, and the requester must hold the request until req_ready.
- rd_tap = shadow[rd_lane] registered, or 0 if rd_lane >= NUM_LANES. It shows the in-flight value during stepping.

## Timing
- Reset values (RST sampled high): req_ready=0, busy=1, done=0, err=0, dly_ce=0, dly_inc=0, dly_rst=1, rd_tap=0.
- dly_rst stays high for every cycle RST is high plus the first INIT cycle after release. The first possible accept is 2 cycles after RST falls.
- Request accepted at cycle N with distance d=|target-current|:
  - CE pulses occur at N+1+k*(1+SETTLE_CYC), for k=0..d-1.
  - done is high at N+1+d*(1+SETTLE_CYC).
  - req_ready returns at the cycle after that.
  - For d=0, done is at N+1.
- err is at N+1 and req_ready stays high throughout, so a new request can be accepted at N+1.
- rd_tap latency is 1 cycle.
- RST mid-operation: the next edge enters INIT and drops dly_ce. The in-flight request is abandoned with no done. The shadow table resets in step with the hardware IODELAY reset.
- All outputs are registered.

## Test plan
- Reset release: RST high 3 cycles then low. Required: dly_rst high on those 3 cycles plus 1; req_ready first high 2 cycles after release; rd_tap of every lane = 0.
- Increment: lane 3 -> tap 5, SETTLE_CYC=4. Required: exactly 5 pulses on dly_ce[3] spaced 5 cycles apart, dly_inc=1, done at N+26, rd_tap(3)=5.
- Decrement plus isolation: after the previous case, lane 3 -> tap 2. Required: 3 pulses with dly_inc=0; no other dly_ce bit ever set; lane 9 readback still 0.
- Null and invalid: lane 7 -> tap 0 gives done at N+1 with no CE. Lane 12 gives err at N+1, no done, and a following valid request accepted at N+1.
- Extremes: lane 11 -> 63, then -> 0. Required: 63 increments then 63 decrements; shadow never outside 0..63; done timing matches the formula.
- Reset mid-walk: lane 0 -> 40, RST asserted after the 10th CE. Required: CE stops at once, no done, dly_rst pulses, rd_tap(0)=0, and a new request completes normally.

Source files
------------

// File: rtl/dac_delay_tuner_if.sv
// Request, status, IODELAY control and readback signals of the DAC delay tuner.
interface dac_delay_tuner_if #(
  parameter int unsigned NUM_LANES = 12,
  parameter int unsigned TAP_W     = 6
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_lane;
  logic [TAP_W-1:0]     req_tap;
  logic                 done;
  logic                 err;
  logic                 busy;
  logic [NUM_LANES-1:0] dly_ce;
  logic                 dly_inc;
  logic                 dly_rst;
  logic [3:0]           rd_lane;
  logic [TAP_W-1:0]     rd_tap;

  // Requester / observer side.
  modport master (
    output req_valid, req_lane, req_tap, rd_lane,
    input  req_ready, done, err, busy, dly_ce, dly_inc, dly_rst, rd_tap
  );

  // Tuner side.
  modport slave (
    input  req_valid, req_lane, req_tap, rd_lane,
    output req_ready, done, err, busy, dly_ce, dly_inc, dly_rst, rd_tap
  );
endinterface

// File: rtl/dac_delay_tuner.sv
// Walks one DAC-lane IODELAY at a time toward a requested tap with CE/INC pulses,
// leaving a settle gap after every step, and keeps a shadow table of current taps.
module dac_delay_tuner #(
  parameter int unsigned NUM_LANES  = 12,
  parameter int unsigned TAP_W      = 6,
  parameter int unsigned INIT_TAP   = 0,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                i_clk200,
  input  logic                i_rst,
  dac_delay_tuner_if.slave    io_tun
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [3:0]  LANES_L = 4'(NUM_LANES);

  typedef enum logic [2:0] {StInit, StIdle, StStep, StSettle, StDone} state_e;

  state_e               r_state, w_state_d;
  logic                 r_init_hold;
  logic [3:0]           r_lane, w_lane_d;
  logic [TAP_W-1:0]     r_target, w_target_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [TAP_W-1:0]     r_shadow [NUM_LANES];

  logic                 r_req_ready, r_busy, r_done, r_err;
  logic [NUM_LANES-1:0] r_dly_ce, w_ce_d;
  logic                 r_dly_inc, w_inc_d;
  logic                 r_dly_rst;
  logic [TAP_W-1:0]     r_rd_tap;

  logic                 w_accept, w_lane_ok, w_err_d;
  logic [TAP_W-1:0]     w_cur_tap, w_walk_tap;

  // Next-state, latched request and registered-output next values.
  always_comb begin
    w_state_d  = r_state;
    w_lane_d   = r_lane;
    w_target_d = r_target;
    w_cnt_d    = r_cnt;
    w_inc_d    = r_dly_inc;
    w_err_d    = 1'b0;
    w_ce_d     = '0;
    w_accept   = io_tun.req_valid && r_req_ready;
    w_lane_ok  = io_tun.req_lane < LANES_L;
    w_cur_tap  = w_lane_ok ? r_shadow[io_tun.req_lane] : '0;
    w_walk_tap = r_shadow[r_lane];

    case (r_state)
      // Holds one extra cycle after reset release so dly_rst outlasts RST.
      StInit: if (!r_init_hold) w_state_d = StIdle;
      StIdle: begin
        if (w_accept) begin
          if (!w_lane_ok) begin
            w_err_d = 1'b1;
          end else if (io_tun.req_tap == w_cur_tap) begin
            w_state_d = StDone;
          end else begin
            w_lane_d   = io_tun.req_lane;
            w_target_d = io_tun.req_tap;
            w_inc_d    = io_tun.req_tap > w_cur_tap;
            w_state_d  = StStep;
          end
        end
      end
      StStep: begin
        w_cnt_d   = CNT_W'(SETTLE_CYC - 1);
        w_state_d = StSettle;
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_state_d = (w_walk_tap == r_target) ? StDone : StStep;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StInit;
    endcase

    if (w_state_d == StStep) w_ce_d[w_lane_d] = 1'b1;
  end

  // Control state register.
  always_ff @(posedge i_clk200) begin
    if (i_rst) begin
      r_state     <= StInit;
      r_init_hold <= 1'b1;
      r_lane      <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_init_hold <= 1'b0;
      r_lane      <= w_lane_d;
      r_target    <= w_target_d;
      r_cnt       <= w_cnt_d;
    end
  end

  // Shadow tap table: reset alongside the IODELAYs, one step per STEP cycle.
  always_ff @(posedge i_clk200) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_shadow[i] <= TAP_W'(INIT_TAP);
    end else if (r_state == StStep) begin
      r_shadow[r_lane] <= r_dly_inc ? r_shadow[r_lane] + 1'b1 : r_shadow[r_lane] - 1'b1;
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge i_clk200) begin
    if (i_rst) begin
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_dly_ce    <= '0;
      r_dly_inc   <= 1'b0;
      r_dly_rst   <= 1'b1;
      r_rd_tap    <= '0;
    end else begin
      r_req_ready <= (w_state_d == StIdle);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
      r_err       <= w_err_d;
      r_dly_ce    <= w_ce_d;
      r_dly_inc   <= w_inc_d;
      r_dly_rst   <= (w_state_d == StInit);
      r_rd_tap    <= (io_tun.rd_lane < LANES_L) ? r_shadow[io_tun.rd_lane] : '0;
    end
  end

  assign io_tun.req_ready = r_req_ready;
  assign io_tun.busy      = r_busy;
  assign io_tun.done      = r_done;
  assign io_tun.err       = r_err;
  assign io_tun.dly_ce    = r_dly_ce;
  assign io_tun.dly_inc   = r_dly_inc;
  assign io_tun.dly_rst   = r_dly_rst;
  assign io_tun.rd_tap    = r_rd_tap;

endmodule

// File: tb/tb_dac_delay_tuner.sv
// Scoreboard bench for dac_delay_tuner: requests push expected CE pulses and
// done/err events computed from tap distances; a monitor pops and compares them.
module tb_dac_delay_tuner;

  localparam int NL     = 12;
  localparam int TW     = 6;
  localparam int SETTLE = 4;
  localparam int PERIOD = 1 + SETTLE;

  typedef struct {
    int              cyc;
    logic [NL-1:0]   ce;
    logic            inc;
  } ce_t;

  typedef struct {
    int   cyc;
    logic is_err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   model [NL];
  ce_t   ce_q[$];
  resp_t resp_q[$];

  dac_delay_tuner_if #(.NUM_LANES(NL), .TAP_W(TW)) tun ();

  dac_delay_tuner #(
    .NUM_LANES (NL),
    .TAP_W     (TW),
    .INIT_TAP  (0),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .i_clk200(clk),
    .i_rst   (rst),
    .io_tun  (tun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expectation for every CE pulse and every done/err pulse.
  task automatic monitor();
    ce_t   e;
    resp_t r;
    forever begin
      @(negedge clk);
      if ((|tun.dly_ce) === 1'b1) begin
        if (ce_q.size() == 0) begin
          check("ce_unexpected", 32'(tun.dly_ce), 32'd0);
        end else begin
          e = ce_q.pop_front();
          check("ce_cycle", cyc, e.cyc);
          check("ce_vec", 32'(tun.dly_ce), 32'(e.ce));
          check("ce_inc", 32'(tun.dly_inc), 32'(e.inc));
        end
      end
      if (tun.done === 1'b1 || tun.err === 1'b1) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", {30'd0, tun.done, tun.err}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          check("resp_cycle", cyc, r.cyc);
          check("resp_kind", {30'd0, tun.done, tun.err}, r.is_err ? 32'd1 : 32'd2);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int lane, input int tap, output int acc);
    int    budget;
    int    d;
    int    cur;
    ce_t   e;
    resp_t r;
    tun.req_valid = 1'b1;
    tun.req_lane  = 4'(lane);
    tun.req_tap   = TW'(tap);
    budget = 0;
    while (tun.req_ready !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      check("accept_timeout", 32'd1, 32'd0);
      acc = cyc;
    end else begin
      acc = cyc;
      if (lane >= NL) begin
        r.cyc = acc + 1;
        r.is_err = 1'b1;
        resp_q.push_back(r);
      end else begin
        cur = model[lane];
        d = (tap > cur) ? tap - cur : cur - tap;
        for (int k = 0; k < d; k++) begin
          e.cyc = acc + 1 + k * PERIOD;
          e.ce  = NL'(1) << lane;
          e.inc = (tap > cur);
          ce_q.push_back(e);
        end
        r.cyc = acc + 1 + d * PERIOD;
        r.is_err = 1'b0;
        resp_q.push_back(r);
        model[lane] = tap;
      end
    end
    @(negedge clk);
    tun.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!(ce_q.size() == 0 && resp_q.size() == 0 && tun.busy === 1'b0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_rd(input int lane, input int exp);
    tun.rd_lane = 4'(lane);
    @(negedge clk);
    check($sformatf("rd_tap_lane%0d", lane), 32'(tun.rd_tap), 32'(exp));
  endtask

  initial begin
    int n_rst;
    int first_rdy;
    int acc;
    int acc2;
    int lane;
    int tap;
    int ce_cnt;
    int budget;

    tun.req_valid = 1'b0;
    tun.req_lane  = '0;
    tun.req_tap   = '0;
    tun.rd_lane   = '0;
    for (int i = 0; i < NL; i++) model[i] = 0;
    fork
      monitor();
    join_none
    fork
      begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset release: RST sampled high on three edges.
    n_rst = 0;
    first_rdy = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("rst_vals", {tun.req_ready, tun.busy, tun.done, tun.err, tun.dly_inc, tun.dly_rst,
                           8'(tun.rd_tap), 16'(tun.dly_ce)}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                           8'd0, 16'd0});
      end
      if (tun.dly_rst === 1'b1) n_rst++;
      if (tun.req_ready === 1'b1 && first_rdy < 0) first_rdy = cyc;
      if (i == 3) rst = 1'b0;
    end
    check("dly_rst_cycles", n_rst, 4);
    check("first_ready_cycle", first_rdy, 3 + 2);
    for (int i = 0; i < NL; i++) check_rd(i, 0);

    // Increment then decrement on lane 3.
    send(3, 5, acc);
    wait_idle();
    check_rd(3, 5);
    send(3, 2, acc);
    wait_idle();
    check_rd(3, 2);
    check_rd(9, 0);

    // Null request, invalid lane, and back-to-back accept after err.
    send(7, 0, acc);
    wait_idle();
    send(12, 5, acc);
    send(4, 1, acc2);
    check("accept_after_err", acc2, acc + 1);
    wait_idle();
    check_rd(4, 1);

    // Extremes on lane 11.
    send(11, 63, acc);
    wait_idle();
    check_rd(11, 63);
    send(11, 0, acc);
    wait_idle();
    check_rd(11, 0);

    // Reset during a walk on lane 0 after its 10th CE pulse.
    send(0, 40, acc);
    ce_cnt = 0;
    budget = 0;
    while (ce_cnt < 10 && budget < 500) begin
      if ((|tun.dly_ce) === 1'b1) ce_cnt++;
      if (ce_cnt < 10) @(negedge clk);
      budget++;
    end
    check("mid_ce_count", ce_cnt, 10);
    rst = 1'b1;
    @(negedge clk);
    ce_q.delete();
    resp_q.delete();
    for (int i = 0; i < NL; i++) model[i] = 0;
    check("mid_rst_ce", 32'(tun.dly_ce), 32'd0);
    check("mid_rst_dly_rst", 32'(tun.dly_rst), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    check_rd(0, 0);
    check_rd(3, 0);
    send(0, 7, acc);
    wait_idle();
    check_rd(0, 7);

    // Randomized requests, including invalid lanes, against the tap model.
    for (int it = 0; it < 14; it++) begin
      lane = $urandom_range(0, 13);
      tap  = $urandom_range(0, 63);
      send(lane, tap, acc);
      wait_idle();
      lane = $urandom_range(0, 15);
      check_rd(lane, (lane < NL) ? model[lane] : 0);
    end

    check("ce_q_left", ce_q.size(), 0);
    check("resp_q_left", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
